sirv_debug_entry_ctrl: RTL and testbench



---
 rtl/sirv_debug_pkg.sv | 20 ++
 rtl/sirv_debug_entry_ctrl.sv | 109 ++++++++++
 tb/tb_sirv_debug_entry_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sirv_debug_pkg.sv
// sirv_debug_pkg: dcause codes and debug entry sequencer state encoding.
package sirv_debug_pkg;

    localparam logic [2:0] DCAUSE_NONE     = 3'd0;
    localparam logic [2:0] DCAUSE_EBREAK   = 3'd1;
    localparam logic [2:0] DCAUSE_TRIGGER  = 3'd2;
    localparam logic [2:0] DCAUSE_DEBUGINT = 3'd3;
    localparam logic [2:0] DCAUSE_STEP     = 3'd4;
    localparam logic [2:0] DCAUSE_HALT     = 3'd5;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_ENTER_FLUSH,
        ST_ENTER_UPD,
        ST_DEBUG,
        ST_EXIT_FLUSH,
        ST_EXIT_UPD
    } dbg_state_e;

endpackage

// File: rtl/sirv_debug_entry_ctrl.sv
// sirv_debug_entry_ctrl: arbitrates debug entry causes, stalls commit, redirects to the debug ROM
// and pulses the dpc/dcause CSR writes; dret restores the pc and leaves debug mode.
module sirv_debug_entry_ctrl
    import sirv_debug_pkg::*;
#(
    parameter int          PC_SIZE      = 32,
    parameter logic [31:0] DBG_ROM_ADDR = 32'h0000_0800,
    parameter logic [31:0] RESET_PC     = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_valid,
    output logic               cmt_ready,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic [PC_SIZE-1:0] cmt_npc,
    input  logic               cmt_ebreak,
    input  logic               cmt_dret,
    input  logic               dbg_irq,
    input  logic               dbg_halt_r,
    input  logic               dbg_step_r,
    input  logic               dbg_ebreakm_r,
    input  logic               dbg_mode,
    input  logic [PC_SIZE-1:0] dpc_r,
    output logic [PC_SIZE-1:0] cmt_dpc,
    output logic               cmt_dpc_ena,
    output logic [2:0]         cmt_dcause,
    output logic               cmt_dcause_ena,
    output logic               flush_req,
    output logic [PC_SIZE-1:0] flush_pc,
    input  logic               flush_ack
);

    localparam logic [PC_SIZE-1:0] ROM_PC  = DBG_ROM_ADDR[PC_SIZE-1:0];
    localparam logic [PC_SIZE-1:0] INIT_PC = RESET_PC[PC_SIZE-1:0];

    dbg_state_e         state_q;
    logic [PC_SIZE-1:0] npc_q;
    logic [PC_SIZE-1:0] ev_dpc;
    logic [2:0]         ev_cause;
    logic               run, ev_brk, ev_halt, ev_step, retire, enter;

    // entry is only considered while the CSR block agrees the hart is running
    assign run       = (state_q == ST_RUN) && !dbg_mode;
    assign ev_brk    = run && cmt_valid && cmt_ebreak && dbg_ebreakm_r;
    assign ev_halt   = run && (dbg_irq || dbg_halt_r);
    assign cmt_ready = (state_q == ST_DEBUG) || (state_q == ST_RUN && !ev_brk && !ev_halt);
    assign retire    = cmt_valid && cmt_ready;
    assign ev_step   = run && retire && dbg_step_r;
    assign enter     = ev_brk || ev_halt || ev_step;
    assign ev_cause  = ev_brk ? DCAUSE_EBREAK : dbg_irq ? DCAUSE_DEBUGINT :
                       dbg_halt_r ? DCAUSE_HALT : DCAUSE_STEP;
    assign ev_dpc    = (ev_brk || (ev_halt && cmt_valid)) ? cmt_pc : ev_halt ? npc_q : cmt_npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            npc_q          <= INIT_PC;
            cmt_dpc        <= '0;
            cmt_dpc_ena    <= 1'b0;
            cmt_dcause     <= DCAUSE_NONE;
            cmt_dcause_ena <= 1'b0;
            flush_req      <= 1'b0;
            flush_pc       <= '0;
        end else begin
            cmt_dpc_ena    <= 1'b0;
            cmt_dcause_ena <= 1'b0;
            if (retire) npc_q <= cmt_npc;
            case (state_q)
                ST_RUN: if (enter) begin
                    state_q    <= ST_ENTER_FLUSH;
                    flush_req  <= 1'b1;
                    flush_pc   <= ROM_PC;
                    cmt_dpc    <= ev_dpc;
                    cmt_dcause <= ev_cause;
                end
                ST_ENTER_FLUSH: if (flush_ack) begin
                    state_q        <= ST_ENTER_UPD;
                    flush_req      <= 1'b0;
                    cmt_dpc_ena    <= 1'b1;
                    cmt_dcause_ena <= 1'b1;
                end
                ST_ENTER_UPD: state_q <= ST_DEBUG;
                ST_DEBUG: begin
                    if (flush_req && flush_ack) flush_req <= 1'b0;
                    if (retire && cmt_dret) begin
                        state_q   <= ST_EXIT_FLUSH;
                        flush_req <= 1'b1;
                        flush_pc  <= dpc_r;
                    end else if (retire && cmt_ebreak) begin
                        flush_req <= 1'b1;
                        flush_pc  <= ROM_PC;
                    end
                end
                ST_EXIT_FLUSH: if (flush_ack) begin
                    state_q        <= ST_EXIT_UPD;
                    flush_req      <= 1'b0;
                    cmt_dcause     <= DCAUSE_NONE;
                    cmt_dcause_ena <= 1'b1;
                end
                ST_EXIT_UPD: begin
                    state_q <= ST_RUN;
                    npc_q   <= dpc_r;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// tb_sirv_debug_entry_ctrl: randomized and directed stimulus against a transaction-level debug model;
// expected flushes and CSR pulses are queued and checked by an independent monitor.
module tb_sirv_debug_entry_ctrl;

    localparam logic [31:0] ROM = 32'h0000_0800;

    typedef struct {logic [31:0] pc; int due; bit upd;} fl_t;
    typedef struct {bit dpc_en; logic [31:0] dpc; logic [2:0] cause;} up_t;

    logic        clk = 0, rst = 1;
    logic        cmt_valid = 0, cmt_ready, cmt_ebreak = 0, cmt_dret = 0;
    logic [31:0] cmt_pc = 0, cmt_npc = 0, dpc_r = 0, cmt_dpc, flush_pc;
    logic        dbg_irq = 0, dbg_halt_r = 0, dbg_step_r = 0, dbg_ebreakm_r = 0, dbg_mode = 0;
    logic        cmt_dpc_ena, cmt_dcause_ena, flush_req, flush_ack = 0;
    logic [2:0]  cmt_dcause;

    int n_chk = 0, n_fail = 0, cyc = 0, upd_due = 0;
    fl_t exp_fl[$];
    up_t exp_up[$];
    fl_t f;
    up_t u;
    bit  fl_pend = 0, fl_upd = 0;
    logic [31:0] fl_pc = 0;

    bit m_wait = 0, m_gap = 0, m_exit = 0, m_dbg = 0, m_dfl = 0;
    logic [31:0] m_npc = 32'h8000_0000, m_dpc = 0;

    sirv_debug_entry_ctrl dut (
        .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
        .cmt_pc(cmt_pc), .cmt_npc(cmt_npc), .cmt_ebreak(cmt_ebreak), .cmt_dret(cmt_dret),
        .dbg_irq(dbg_irq), .dbg_halt_r(dbg_halt_r), .dbg_step_r(dbg_step_r),
        .dbg_ebreakm_r(dbg_ebreakm_r), .dbg_mode(dbg_mode), .dpc_r(dpc_r),
        .cmt_dpc(cmt_dpc), .cmt_dpc_ena(cmt_dpc_ena), .cmt_dcause(cmt_dcause),
        .cmt_dcause_ena(cmt_dcause_ena), .flush_req(flush_req), .flush_pc(flush_pc),
        .flush_ack(flush_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: samples after the driver has settled each negedge
    always begin
        @(negedge clk);
        #2;
        if (rst) fl_pend = 0;
        else begin
            if (fl_pend) begin
                chk("flush_held", flush_req, 1);
                chk("flush_pc_stable", flush_pc, fl_pc);
                if (!flush_req) fl_pend = 0;
            end else if (flush_req) begin
                chk("flush_expected", exp_fl.size() != 0, 1);
                fl_pend = 1;
                fl_pc = flush_pc;
                fl_upd = 0;
                if (exp_fl.size() != 0) begin
                    f = exp_fl.pop_front();
                    chk("flush_pc", flush_pc, f.pc);
                    chk("flush_latency", cyc, f.due);
                    fl_upd = f.upd;
                end
            end
            if (flush_req && flush_ack) begin
                fl_pend = 0;
                if (fl_upd) upd_due = cyc + 1;
            end
            if (cmt_dpc_ena || cmt_dcause_ena) begin
                chk("upd_expected", exp_up.size() != 0, 1);
                if (exp_up.size() != 0) begin
                    u = exp_up.pop_front();
                    chk("dpc_ena", cmt_dpc_ena, u.dpc_en);
                    chk("dcause_ena", cmt_dcause_ena, 1);
                    if (u.dpc_en) chk("dpc", cmt_dpc, u.dpc);
                    chk("dcause", cmt_dcause, u.cause);
                    chk("upd_latency", cyc, upd_due);
                end
            end
        end
    end

    task automatic tick(input bit v, input logic [31:0] pc, input logic [31:0] npc, input bit eb,
                        input bit dr, input bit irq, input bit halt, input bit step, input bit ebm,
                        input bit ack);
        bit rdy, ret, brk, ev;
        logic [2:0]  c;
        logic [31:0] d;
        @(negedge clk);
        cmt_valid = v; cmt_pc = pc; cmt_npc = npc; cmt_ebreak = eb; cmt_dret = dr;
        dbg_irq = irq; dbg_halt_r = halt; dbg_step_r = step; dbg_ebreakm_r = ebm;
        flush_ack = ack; dpc_r = m_dpc; dbg_mode = m_dbg;
        brk = v && eb && ebm;
        rdy = !(m_wait || m_gap) && (m_dbg || !(brk || irq || halt));
        #1 chk("cmt_ready", cmt_ready, rdy);
        ret = v && rdy;
        if (m_wait) begin
            if (ack) begin m_wait = 0; m_gap = 1; end
        end else if (m_gap) begin
            m_gap = 0;
            m_dbg = !m_exit;
            if (m_exit) m_npc = m_dpc;
        end else if (m_dbg) begin
            if (m_dfl && ack) m_dfl = 0;
            if (ret) m_npc = npc;
            if (ret && dr) begin
                exp_fl.push_back('{m_dpc, cyc + 1, 1'b1});
                exp_up.push_back('{1'b0, 32'h0, 3'd0});
                m_wait = 1; m_exit = 1;
            end else if (ret && eb) begin
                exp_fl.push_back('{ROM, cyc + 1, 1'b0});
                m_dfl = 1;
            end
        end else begin
            ev = brk || irq || halt || (ret && step);
            c = brk ? 3'd1 : irq ? 3'd3 : halt ? 3'd5 : 3'd4;
            d = brk ? pc : (irq || halt) ? (v ? pc : m_npc) : npc;
            if (ret) m_npc = npc;
            if (ev) begin
                exp_fl.push_back('{ROM, cyc + 1, 1'b1});
                exp_up.push_back('{1'b1, d, c});
                m_wait = 1; m_exit = 0; m_dpc = d;
            end
        end
    endtask

    task automatic idle(input int n, input bit ack);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
    endtask

    task automatic settle(input int hold);
        idle(hold, 0);
        for (int i = 0; i < 20 && (m_wait || m_gap); i++) idle(1, 1);
    endtask

    task automatic do_exit(input int hold, input bit step);
        tick(1, 32'h0000_0810, 32'h0000_0814, 0, 1, 0, 0, step, 0, 0);
        settle(hold);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_flush_req", flush_req, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_dpc", cmt_dpc, 0);
        chk("rst_dcause", cmt_dcause, 0);
        chk("rst_dpc_ena", cmt_dpc_ena, 0);
        chk("rst_dcause_ena", cmt_dcause_ena, 0);
        rst = 0;
        idle(2, 1);
        // halt while an instruction is presented
        tick(1, 32'h8000_0010, 32'h8000_0014, 0, 0, 0, 1, 0, 0, 1);
        settle(0);
        idle(2, 1);
        do_exit(0, 0);
        // ebreak beats a simultaneous debug interrupt; with ebreakm clear it just retires
        tick(1, 32'h8000_0020, 32'h8000_0024, 1, 0, 1, 0, 0, 1, 1);
        settle(1);
        tick(1, 32'h0000_0800, 32'h0000_0804, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 1);
        do_exit(2, 0);
        tick(1, 32'h8000_0020, 32'h8000_0024, 1, 0, 0, 0, 0, 0, 1);
        idle(2, 0);
        // single step, then exit with step still set: one retire and re-entry
        tick(1, 32'h8000_0100, 32'h8000_0104, 0, 0, 0, 0, 1, 0, 1);
        settle(0);
        do_exit(0, 1);
        tick(1, 32'h8000_0104, 32'h8000_0108, 0, 0, 0, 0, 1, 0, 0);
        settle(2);
        m_dpc = 32'h8000_0200;
        do_exit(3, 0);
        // debug interrupt with nothing presented uses the tracked next pc
        tick(1, 32'h8000_02fc, 32'h8000_0300, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        settle(0);
        do_exit(1, 0);
        for (int i = 0; i < 1500; i++) begin
            bit v, eb, dr;
            logic [31:0] pc;
            pc = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
            v = ($urandom % 4 != 0) && !(m_dbg && m_dfl);
            eb = ($urandom % 8 == 0);
            dr = !eb && ($urandom % (m_dbg ? 6 : 12) == 0);
            if (m_dbg && !m_wait && $urandom % 10 == 0) m_dpc = pc ^ 32'h0000_1000;
            tick(v, pc, pc + 4, eb, dr, $urandom % 25 == 0, $urandom % 30 == 0,
                 $urandom % 20 == 0, $urandom % 2 == 1, $urandom % 3 != 0);
        end
        settle(0);
        if (m_dbg) do_exit(0, 0);
        idle(3, 1);
        // reset while the entry flush is outstanding
        tick(1, 32'h8000_0400, 32'h8000_0404, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid_flush_req", flush_req, 0);
        chk("rst_mid_dpc_ena", cmt_dpc_ena, 0);
        exp_fl.delete();
        exp_up.delete();
        m_wait = 0; m_gap = 0; m_dbg = 0; m_dfl = 0; m_npc = 32'h8000_0000;
        @(negedge clk);
        rst = 0;
        idle(4, 1);
        chk("post_rst_flush_req", flush_req, 0);
        chk("fl_queue_empty", exp_fl.size(), 0);
        chk("up_queue_empty", exp_up.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
